// File: rtl/program_counter_unit.sv
// program_counter_unit: fetch-address generator with redirect handling.
// Purpose: holds the fetch PC. It advances by 4, holds on Stall, and redirects on
//   JR / Jump / taken branch. After a redirect it raises Flush for one cycle.
// Optional feature: define BRANCH_STATS_EN to build a saturating redirect
//   counter on TakenCount. Without the macro, TakenCount is tied to zero.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   Stall                 - hold sequential advance
//   BranchControlSignal   - taken branch; target BranchBasePC + (BranchOffset<<2)
//   BranchBasePC          - PC+4 of resolving branch/jump
//   BranchOffset          - sign-extended word offset
//   Jump, JumpTarget      - J-format redirect, 26-bit index
//   JR, JRAddress         - register-jump redirect
//   PC, PCPlus4           - current fetch address and its successor (comb)
//   Flush                 - kill wrong-path instruction in IF/ID
//   FetchValid            - PC is fetch-worthy
//   TakenCount            - redirect statistics
module program_counter_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             BranchControlSignal,
  input  logic [31:0]      BranchBasePC,
  input  logic [31:0]      BranchOffset,
  input  logic             Jump,
  input  logic [25:0]      JumpTarget,
  input  logic             JR,
  input  logic [31:0]      JRAddress,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             Flush,
  output logic             FetchValid,
  output logic [CNT_W-1:0] TakenCount
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        redirect_c;
  logic [31:0] target_c;

  // Redirect detection and target selection, priority JR > Jump > Branch
  always_comb begin
    redirect_c = (state_q != IDLE) && (JR || Jump || BranchControlSignal);
    if (JR) begin
      target_c = {JRAddress[31:2], 2'b00};
    end else if (Jump) begin
      target_c = {BranchBasePC[31:28], JumpTarget, 2'b00};
    end else begin
      target_c = BranchBasePC + (BranchOffset << 2);
    end
  end

  // Next-state and next-PC logic; flags are derived from the next state so they register with it
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN, FLUSH: begin
        if (redirect_c) begin
          pc_d    = target_c;
          state_d = FLUSH;
        end else begin
          state_d = RUN;
          if (!Stall) pc_d = pc_q + 32'd4;
        end
      end
      default: state_d = IDLE;
    endcase
    fetch_valid_d = (state_d != IDLE);
    flush_d       = (state_d == FLUSH);
  end

  // State and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign PC         = pc_q;
  assign PCPlus4    = pc_q + 32'd4;
  assign Flush      = flush_q;
  assign FetchValid = fetch_valid_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating redirect counter
  always_comb begin
    cnt_d = cnt_q;
    if (redirect_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign TakenCount = cnt_q;
`else
  assign TakenCount = '0;
`endif

endmodule

// File: tb/tb_program_counter_unit.sv
// Testbench for program_counter_unit: directed scenarios plus randomized
// traffic checked against a behavioural model of the fetch PC.
module tb_program_counter_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int unsigned CW     = 2;

  logic          clk;
  logic          reset;
  logic          Stall;
  logic          BranchControlSignal;
  logic [31:0]   BranchBasePC;
  logic [31:0]   BranchOffset;
  logic          Jump;
  logic [25:0]   JumpTarget;
  logic          JR;
  logic [31:0]   JRAddress;
  logic [31:0]   PC;
  logic [31:0]   PCPlus4;
  logic          Flush;
  logic          FetchValid;
  logic [CW-1:0] TakenCount;

  int total = 0;
  int bad   = 0;

  // Behavioural model
  logic [31:0] m_pc;
  bit          m_run;
  bit          m_flush;
  int          m_cnt;

  program_counter_unit #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Stall(Stall),
    .BranchControlSignal(BranchControlSignal), .BranchBasePC(BranchBasePC),
    .BranchOffset(BranchOffset), .Jump(Jump), .JumpTarget(JumpTarget),
    .JR(JR), .JRAddress(JRAddress), .PC(PC), .PCPlus4(PCPlus4),
    .Flush(Flush), .FetchValid(FetchValid), .TakenCount(TakenCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat_max();
`ifdef BRANCH_STATS_EN
    return (1 << CW) - 1;
`else
    return 0;
`endif
  endfunction

  // Apply one rising edge to the model, then sample the DUT 1ns later
  task automatic step();
    bit redir;
    logic [31:0] tgt;
    @(posedge clk);
    if (reset) begin
      m_pc = RST_PC; m_run = 0; m_flush = 0; m_cnt = 0;
    end else if (!m_run) begin
      m_run = 1; m_flush = 0;
    end else begin
      redir = JR | Jump | BranchControlSignal;
      if (JR)        tgt = JRAddress & 32'hFFFF_FFFC;
      else if (Jump) tgt = (BranchBasePC & 32'hF000_0000) | (32'(JumpTarget) * 4);
      else           tgt = BranchBasePC + BranchOffset * 4;
      if (redir) begin
        m_pc = tgt; m_flush = 1;
        if (m_cnt < sat_max()) m_cnt = m_cnt + 1;
      end else begin
        m_flush = 0;
        if (!Stall) m_pc = m_pc + 4;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; Stall = 0; BranchControlSignal = 0; BranchBasePC = '0;
    BranchOffset = '0; Jump = 0; JumpTarget = '0; JR = 0; JRAddress = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; JR = 1; JRAddress = 32'h1234_5678;
    step(); step();
    total++; if (PC !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PC, RST_PC); end
    total++; if (FetchValid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", FetchValid); end
    total++; if (Flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", Flush); end
    total++; if (TakenCount !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", TakenCount); end
    idle_inputs();
    step();
    total++; if (FetchValid !== 1'b1 || PC !== RST_PC) begin bad++; $display("FAIL idle_to_run got fv=%b pc=%h exp fv=1 pc=%h", FetchValid, PC, RST_PC); end
    step();
    total++; if (PC !== 32'h0040_0004) begin bad++; $display("FAIL first_advance got=%h exp=00400004", PC); end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = PC;
    Stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (PC !== held || PCPlus4 !== held + 32'd4) begin bad++; $display("FAIL stall_hold got pc=%h p4=%h exp pc=%h", PC, PCPlus4, held); end
    end
    Stall = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (PC !== held + 32'(4 * i)) begin bad++; $display("FAIL stall_release got=%h exp=%h", PC, held + 32'(4 * i)); end
    end
  endtask

  task automatic test_branch();
    BranchControlSignal = 1; BranchBasePC = 32'h0040_0010; BranchOffset = 32'hFFFF_FFFC;
    step();
    total++; if (PC !== 32'h0040_0000 || Flush !== 1'b1) begin bad++; $display("FAIL branch got pc=%h flush=%b exp pc=00400000 flush=1", PC, Flush); end
    idle_inputs(); Stall = 1;
    step();
    total++; if (Flush !== 1'b0 || PC !== 32'h0040_0000) begin bad++; $display("FAIL branch_flush_once got pc=%h flush=%b exp pc=00400000 flush=0", PC, Flush); end
    Stall = 0;
  endtask

  task automatic test_priority();
    JR = 1; Jump = 1; BranchControlSignal = 1; Stall = 1;
    JRAddress = 32'h1000_0007; JumpTarget = 26'h3FF_FFFF;
    BranchBasePC = 32'h2000_0000; BranchOffset = 32'd8;
    step();
    total++; if (PC !== 32'h1000_0004 || Flush !== 1'b1) begin bad++; $display("FAIL priority_jr got pc=%h flush=%b exp pc=10000004 flush=1", PC, Flush); end
    JR = 0;
    step();
    total++; if (PC !== 32'h2FFF_FFFC || Flush !== 1'b1) begin bad++; $display("FAIL priority_jump got pc=%h flush=%b exp pc=2ffffffc flush=1", PC, Flush); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    JR = 1; JRAddress = 32'hFFFF_FFFF;
    step();
    total++; if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin bad++; $display("FAIL wrap_load got pc=%h p4=%h exp pc=fffffffc p4=0", PC, PCPlus4); end
    idle_inputs();
    step();
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL wrap got=%h exp=00000000", PC); end
  endtask

  task automatic test_stats();
    int exp_cnt;
`ifdef BRANCH_STATS_EN
    exp_cnt = 3;
`else
    exp_cnt = 0;
`endif
    idle_inputs(); reset = 1; step();
    reset = 0; step();
    BranchControlSignal = 1; BranchBasePC = 32'h0000_1000; BranchOffset = 32'd1;
    for (int i = 0; i < 5; i++) step();
    total++; if (int'(TakenCount) !== exp_cnt) begin bad++; $display("FAIL stats_sat got=%0d exp=%0d", TakenCount, exp_cnt); end
    total++; if (Flush !== 1'b1) begin bad++; $display("FAIL stats_in_flush got=%b exp=1", Flush); end
    reset = 1; step();
    total++; if (TakenCount !== '0 || Flush !== 1'b0 || FetchValid !== 1'b0) begin bad++; $display("FAIL reset_in_flush got cnt=%0d flush=%b fv=%b exp 0 0 0", TakenCount, Flush, FetchValid); end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      Stall = ($urandom_range(0, 2) == 0);
      JR = ($urandom_range(0, 9) == 0);
      Jump = ($urandom_range(0, 9) == 0);
      BranchControlSignal = ($urandom_range(0, 5) == 0);
      BranchBasePC = $urandom; BranchOffset = $urandom;
      if ($urandom_range(0, 1) == 1) BranchOffset = 32'($signed(BranchOffset[15:0]));
      JumpTarget = 26'($urandom); JRAddress = $urandom;
      step();
      total++; if (PC !== m_pc || PCPlus4 !== m_pc + 32'd4) begin bad++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, PC, m_pc); end
      total++; if (Flush !== m_flush || FetchValid !== m_run) begin bad++; $display("FAIL rand_flags cyc=%0d got flush=%b fv=%b exp flush=%b fv=%b", i, Flush, FetchValid, m_flush, m_run); end
      total++; if (int'(TakenCount) !== m_cnt) begin bad++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", i, TakenCount, m_cnt); end
    end
    idle_inputs();
  endtask

  initial begin
    m_pc = RST_PC; m_run = 0; m_flush = 0; m_cnt = 0;
    idle_inputs();
    test_reset();
    test_stall();
    test_branch();
    test_priority();
    test_wrap();
    test_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
